// File: rtl/lbm_pkg.sv
// Shared lattice-Boltzmann definitions: grid geometry, phase encoding and RAM widths.
package lbm_pkg;

  localparam int unsigned GRID_W        = 4;
  localparam int unsigned GRID_H        = 3;
  localparam int unsigned DEPTH         = GRID_W * GRID_H;
  localparam int unsigned ADDR_W        = $clog2(DEPTH);
  localparam int unsigned DATA_WIDTH    = 16;
  localparam int unsigned ADDRESS_WIDTH = ADDR_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STREAM  = 3'd1,
    BOUNCE  = 3'd2,
    ZERO    = 3'd3,
    COLLIDE = 3'd4,
    DRAIN   = 3'd5
  } phase_t;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lbm_cell_walker.sv
// Raster walker over the lattice: linear cell address plus row/column counters.
module lbm_cell_walker #(
  parameter int unsigned GRID_W = lbm_pkg::GRID_W,
  parameter int unsigned GRID_H = lbm_pkg::GRID_H,
  localparam int unsigned DEPTH  = GRID_W * GRID_H,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned ROW_W  = lbm_pkg::cnt_w(GRID_H),
  localparam int unsigned COL_W  = lbm_pkg::cnt_w(GRID_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              last
);

  logic col_last;

  assign last     = (cell_addr == ADDR_W'(DEPTH - 1));
  assign col_last = (col == COL_W'(GRID_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cell_addr <= '0;
      row       <= '0;
      col       <= '0;
    end else if (clear) begin
      cell_addr <= '0;
      row       <= '0;
      col       <= '0;
    end else if (advance) begin
      if (last) begin
        cell_addr <= '0;
        row       <= '0;
        col       <= '0;
      end else begin
        cell_addr <= cell_addr + ADDR_W'(1);
        if (col_last) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/lbm_step_sequencer.sv
// Timestep sequencer: walks the lattice through stream, bounce-back, zero, collide and drain.
module lbm_step_sequencer #(
  parameter int unsigned GRID_W      = lbm_pkg::GRID_W,
  parameter int unsigned GRID_H      = lbm_pkg::GRID_H,
  parameter int unsigned COLLIDE_LAT = 4,
  parameter int unsigned STEP_W      = 16,
  localparam int unsigned DEPTH      = GRID_W * GRID_H,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              stall,
  input  logic              barrier,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase,
  output logic [ADDR_W-1:0] cell_addr,
  output logic              rd_en,
  output logic              wr_en,
  output logic [3:0]        nb_ok,
  output logic [STEP_W-1:0] steps_done
);

  localparam int unsigned ROW_W   = lbm_pkg::cnt_w(GRID_H);
  localparam int unsigned COL_W   = lbm_pkg::cnt_w(GRID_W);
  localparam int unsigned DRAIN_W = lbm_pkg::cnt_w(COLLIDE_LAT);

  lbm_pkg::phase_t     phase_q, phase_d;
  logic                sub_q, sub_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [STEP_W-1:0]   target_q, target_d;
  logic                done_q, done_d;
  logic                walk_adv, walk_clr, last;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;

  lbm_cell_walker #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_walker (
    .clk       (clk),
    .rst       (rst),
    .clear     (walk_clr),
    .advance   (walk_adv),
    .cell_addr (cell_addr),
    .row       (row),
    .col       (col),
    .last      (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= lbm_pkg::IDLE;
      sub_q    <= 1'b0;
      drain_q  <= '0;
      steps_q  <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      sub_q    <= sub_d;
      drain_q  <= drain_d;
      steps_q  <= steps_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  // sub_q marks the second cycle of a cell: STREAM write, or BOUNCE barrier write.
  always_comb begin
    phase_d  = phase_q;
    sub_d    = sub_q;
    drain_d  = drain_q;
    steps_d  = steps_q;
    target_d = target_q;
    done_d   = 1'b0;
    walk_adv = 1'b0;
    walk_clr = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;

    case (phase_q)
      lbm_pkg::IDLE: begin
        if (start) begin
          target_d = num_steps;
          steps_d  = '0;
          walk_clr = 1'b1;
          if (num_steps == '0) done_d  = 1'b1;
          else                 phase_d = lbm_pkg::STREAM;
        end
      end
      lbm_pkg::STREAM: begin
        rd_en    = !sub_q;
        wr_en    = sub_q;
        sub_d    = !sub_q;
        walk_adv = sub_q;
        if (sub_q && last) phase_d = lbm_pkg::BOUNCE;
      end
      lbm_pkg::BOUNCE: begin
        rd_en    = !sub_q;
        wr_en    = sub_q;
        sub_d    = !sub_q && barrier;
        walk_adv = sub_q || !barrier;
        if ((sub_q || !barrier) && last) phase_d = lbm_pkg::ZERO;
      end
      lbm_pkg::ZERO: begin
        wr_en    = barrier;
        walk_adv = 1'b1;
        if (last) phase_d = lbm_pkg::COLLIDE;
      end
      lbm_pkg::COLLIDE: begin
        rd_en    = 1'b1;
        walk_adv = 1'b1;
        if (last) begin
          phase_d = lbm_pkg::DRAIN;
          drain_d = '0;
        end
      end
      lbm_pkg::DRAIN: begin
        if (drain_q == DRAIN_W'(COLLIDE_LAT - 1)) begin
          drain_d = '0;
          steps_d = steps_q + STEP_W'(1);
          if (steps_d == target_q) begin
            phase_d = lbm_pkg::IDLE;
            done_d  = 1'b1;
          end else begin
            phase_d = lbm_pkg::STREAM;
          end
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: phase_d = lbm_pkg::IDLE;
    endcase

    // Backpressure holds every register; strobes keep their current decode.
    if (stall) begin
      phase_d  = phase_q;
      sub_d    = sub_q;
      drain_d  = drain_q;
      steps_d  = steps_q;
      target_d = target_q;
      done_d   = done_q;
      walk_adv = 1'b0;
      walk_clr = 1'b0;
    end

    if (abort) begin
      phase_d  = lbm_pkg::IDLE;
      sub_d    = 1'b0;
      drain_d  = '0;
      steps_d  = steps_q;
      target_d = target_q;
      done_d   = 1'b0;
      walk_adv = 1'b0;
      walk_clr = 1'b1;
    end
  end

  assign busy       = (phase_q != lbm_pkg::IDLE);
  assign done       = done_q;
  assign phase      = phase_q;
  assign steps_done = steps_q;
  // Bit order {row!=H-1, row!=0, col!=W-1, col!=0}: cell 0 decodes to 4'b1010.
  assign nb_ok = {row != ROW_W'(GRID_H - 1), row != '0, col != COL_W'(GRID_W - 1), col != '0};

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Bench for lbm_step_sequencer: vector table, hand-written corner sequences, random runs vs a cell-trace model.
module tb_lbm_step_sequencer;

  localparam int unsigned GW    = 4;
  localparam int unsigned GH    = 3;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = GW * GH;

  logic        clk = 1'b0;
  logic        rst, start, abort, stall, barrier;
  logic [15:0] num_steps;
  logic        busy, done, rd_en, wr_en;
  logic [2:0]  phase;
  logic [3:0]  cell_addr, nb_ok;
  logic [15:0] steps_done;
  logic [DEPTH-1:0] bar_map;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [2:0]  ph;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] steps;
  } rec_t;

  typedef struct {
    int          ns;
    logic [11:0] bar;
    int          stall_at;
    int          stall_len;
    int          exp_busy;
    int          exp_bounce;
    logic [11:0] exp_zmask;
  } vec_t;

  typedef struct {
    int         addr;
    logic [3:0] nb;
  } nb_vec_t;

  lbm_step_sequencer #(
    .GRID_W(GW), .GRID_H(GH), .COLLIDE_LAT(LAT), .STEP_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_steps(num_steps),
    .stall(stall), .barrier(barrier), .busy(busy), .done(done), .phase(phase),
    .cell_addr(cell_addr), .rd_en(rd_en), .wr_en(wr_en), .nb_ok(nb_ok),
    .steps_done(steps_done)
  );

  always #5 clk = ~clk;
  assign barrier = bar_map[cell_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [3:0] exp_nb(input int a);
    int r, c;
    r = a / GW;
    c = a % GW;
    return {r != GH - 1, r != 0, c != GW - 1, c != 0};
  endfunction

  task automatic wait_phase(input logic [2:0] ph, input logic [15:0] st);
    int n = 0;
    while (!(phase == ph && steps_done == st) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_phase", 32'({phase, steps_done}), 32'({ph, st}));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 32'(busy), 32'(0));
  endtask

  // Runs one job and tallies busy cycles, BOUNCE cells, ZERO writes and STREAM reads.
  task automatic run_vector(input vec_t v);
    int cyc = 0, bounce = 0, reads = 0;
    logic [11:0] zmask = '0;
    logic stl;
    @(negedge clk);
    bar_map = v.bar; num_steps = 16'(v.ns); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && cyc < 3000) begin
      stl = (cyc >= v.stall_at) && (cyc < v.stall_at + v.stall_len);
      stall = stl;
      if (!stl && phase == 3'd2) bounce++;
      if (!stl && phase == 3'd1 && rd_en) reads++;
      if (phase == 3'd3 && wr_en) zmask[cell_addr] = 1'b1;
      cyc++;
      @(negedge clk);
    end
    stall = 1'b0;
    check("vec_busy_cycles", 32'(cyc), 32'(v.exp_busy));
    check("vec_bounce_cycles", 32'(bounce), 32'(v.exp_bounce));
    check("vec_zero_writes", 32'(zmask), 32'(v.exp_zmask));
    check("vec_stream_reads", 32'(reads), 32'(DEPTH * v.ns));
    check("vec_done", 32'(done), 32'(1));
    check("vec_steps_done", 32'(steps_done), 32'(v.ns));
    @(negedge clk);
    check("vec_done_pulse", 32'(done), 32'(0));
  endtask

  // Expected per-cycle cell operations, with random stalls and ignored start pulses.
  task automatic run_random(input int ns, input logic [11:0] bar);
    rec_t q[$];
    rec_t act;
    int n = 0;
    logic stl;
    for (int s = 0; s < ns; s++) begin
      for (int c = 0; c < DEPTH; c++) begin
        q.push_back('{ph: 3'd1, addr: 4'(c), rd: 1'b1, wr: 1'b0, steps: 16'(s)});
        q.push_back('{ph: 3'd1, addr: 4'(c), rd: 1'b0, wr: 1'b1, steps: 16'(s)});
      end
      for (int c = 0; c < DEPTH; c++) begin
        q.push_back('{ph: 3'd2, addr: 4'(c), rd: 1'b1, wr: 1'b0, steps: 16'(s)});
        if (bar[c]) q.push_back('{ph: 3'd2, addr: 4'(c), rd: 1'b0, wr: 1'b1, steps: 16'(s)});
      end
      for (int c = 0; c < DEPTH; c++)
        q.push_back('{ph: 3'd3, addr: 4'(c), rd: 1'b0, wr: bar[c], steps: 16'(s)});
      for (int c = 0; c < DEPTH; c++)
        q.push_back('{ph: 3'd4, addr: 4'(c), rd: 1'b1, wr: 1'b0, steps: 16'(s)});
      for (int d = 0; d < LAT; d++)
        q.push_back('{ph: 3'd5, addr: 4'd0, rd: 1'b0, wr: 1'b0, steps: 16'(s)});
    end
    @(negedge clk);
    bar_map = bar; num_steps = 16'(ns); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (q.size() > 0 && n < 5000) begin
      act = '{ph: phase, addr: cell_addr, rd: rd_en, wr: wr_en, steps: steps_done};
      check("trace", 32'(act), 32'(q[0]));
      check("trace_nb_ok", 32'(nb_ok), 32'(exp_nb(int'(q[0].addr))));
      stl = ($urandom_range(0, 7) == 0);
      stall = stl;
      start = ($urandom_range(0, 15) == 0);
      num_steps = 16'($urandom_range(0, 9));
      if (!stl) void'(q.pop_front());
      @(negedge clk);
      n++;
    end
    stall = 1'b0; start = 1'b0;
    check("trace_len", 32'(q.size()), 32'(0));
    check("rand_done", 32'({busy, done}), 32'({1'b0, 1'b1}));
    check("rand_steps", 32'(steps_done), 32'(ns));
    @(negedge clk);
    check("rand_done_pulse", 32'(done), 32'(0));
  endtask

  initial begin
    vec_t    vecs[5];
    nb_vec_t nbv[4];
    logic    seen;

    vecs[0] = '{ns: 1, bar: 12'h000, stall_at: 0,  stall_len: 0, exp_busy: 64,  exp_bounce: 12, exp_zmask: 12'h000};
    vecs[1] = '{ns: 1, bar: 12'h060, stall_at: 0,  stall_len: 0, exp_busy: 66,  exp_bounce: 14, exp_zmask: 12'h060};
    vecs[2] = '{ns: 1, bar: 12'h000, stall_at: 5,  stall_len: 3, exp_busy: 67,  exp_bounce: 12, exp_zmask: 12'h000};
    vecs[3] = '{ns: 2, bar: 12'h801, stall_at: 10, stall_len: 2, exp_busy: 134, exp_bounce: 28, exp_zmask: 12'h801};
    vecs[4] = '{ns: 3, bar: 12'hfff, stall_at: 0,  stall_len: 0, exp_busy: 228, exp_bounce: 72, exp_zmask: 12'hfff};
    nbv[0] = '{addr: 0,  nb: 4'b1010};
    nbv[1] = '{addr: 3,  nb: 4'b1001};
    nbv[2] = '{addr: 8,  nb: 4'b0110};
    nbv[3] = '{addr: 11, nb: 4'b0101};

    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    num_steps = '0; bar_map = '0;
    @(negedge clk);
    check("reset_phase", 32'(phase), 32'(0));
    check("reset_addr", 32'(cell_addr), 32'(0));
    check("reset_strobes", 32'({busy, done, rd_en, wr_en}), 32'(0));
    check("reset_steps", 32'(steps_done), 32'(0));
    check("reset_nb_ok", 32'(nb_ok), 32'(4'b1010));
    rst = 1'b0;

    foreach (vecs[i]) run_vector(vecs[i]);

    // Neighbour flags at the grid corners, observed during COLLIDE (one cell per cycle).
    @(negedge clk);
    bar_map = '0; num_steps = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_phase(3'd4, 16'd0);
    for (int k = 0; k < DEPTH; k++) begin
      foreach (nbv[j]) begin
        if (nbv[j].addr == k) begin
          check("corner_addr", 32'(cell_addr), 32'(k));
          check("corner_nb_ok", 32'(nb_ok), 32'(nbv[j].nb));
        end
      end
      @(negedge clk);
    end
    wait_idle();

    // Zero-step start: done next cycle, never busy.
    @(negedge clk);
    num_steps = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 32'({busy, done}), 32'({1'b0, 1'b1}));
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | busy | done;
    end
    check("zero_quiet", 32'(seen), 32'(0));

    // Abort during COLLIDE of step 2 of 3, asserted together with stall.
    num_steps = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_phase(3'd4, 16'd1);
    repeat (3) @(negedge clk);
    abort = 1'b1; stall = 1'b1;
    @(negedge clk);
    abort = 1'b0; stall = 1'b0;
    check("abort_idle", 32'({busy, phase}), 32'(0));
    check("abort_steps", 32'(steps_done), 32'(1));
    check("abort_addr", 32'(cell_addr), 32'(0));
    seen = done;
    repeat (20) begin
      @(negedge clk);
      seen = seen | done;
    end
    check("abort_no_done", 32'(seen), 32'(0));

    // Asynchronous reset mid-run.
    num_steps = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_state", 32'({busy, done, rd_en, wr_en, phase}), 32'(0));
    check("midrst_addr", 32'(cell_addr), 32'(0));
    check("midrst_steps", 32'(steps_done), 32'(0));
    check("midrst_nb_ok", 32'(nb_ok), 32'(4'b1010));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_done", 32'({busy, done}), 32'(0));

    for (int r = 0; r < 6; r++)
      run_random($urandom_range(1, 3), 12'($urandom));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
